ftm_recovery_ctrl: RTL and testbench



---
 rtl/ftm_pkg.sv | 14 +
 rtl/ftm_timer.sv | 28 ++
 rtl/ftm_recovery_ctrl.sv | 130 +++++++++++++
 tb/tb_ftm_recovery_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ftm_pkg.sv
// Shared types and widths for the lockstep recovery sequencer.
// No logic; no latency.
// No flow control.
package ftm_pkg;
  localparam int RetryCntW = 4;
  localparam int RecCntW   = 16;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RECOVER,
    RESET
  } ftm_state_e;
endpackage

// File: rtl/ftm_timer.sv
// Loadable down-counter; tc_o flags a count of zero and the counter holds there.
// Load takes effect at the next edge; tc_o follows the count combinationally.
// No flow control; load_i has priority over counting.
module ftm_timer #(
  parameter int Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic             tc_o
);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - Width'(1);
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/ftm_recovery_ctrl.sv
// Lockstep recovery sequencer: mismatch -> debug halt -> checkpoint steering -> done, with reset escalation.
// One cycle from sampled input to registered output; optional watchdog under FTM_WATCHDOG_EN.
// No flow control; mismatch_i is ignored outside IDLE.
module ftm_recovery_ctrl
  import ftm_pkg::*;
#(
  parameter int MaxRetries    = 3,
  parameter int TimeoutCycles = 1024,
  parameter int ResetCycles   = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 enable_i,
  input  logic                 mismatch_i,
  input  logic                 debug_mode_i,
  input  logic                 recovery_done_i,
  output logic                 recover_o,
  output logic                 recovering_o,
  output logic                 reset_o,
  output logic                 error_o,
  output logic [RetryCntW-1:0] retry_cnt_o,
  output logic [RecCntW-1:0]   recoveries_o
);

  localparam logic [RetryCntW-1:0] MaxRetriesC = RetryCntW'(MaxRetries);
  localparam int                   RstW        = $clog2(ResetCycles + 1);

  ftm_state_e state_q, state_d;
  logic       retry_inc, rec_inc, rst_tc, timeout;
  logic       reset_entry;

  // Held loaded while outside RESET so the hold count starts on the entry edge.
  ftm_timer #(.Width(RstW)) u_rst_timer (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (state_q != RESET),
    .load_val_i (RstW'(ResetCycles - 1)),
    .tc_o       (rst_tc)
  );

`ifdef FTM_WATCHDOG_EN
  localparam int WdW = $clog2(TimeoutCycles + 1);

  logic wd_tc;

  ftm_timer #(.Width(WdW)) u_wd_timer (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     ((state_q != REQ) && (state_q != RECOVER)),
    .load_val_i (WdW'(TimeoutCycles)),
    .tc_o       (wd_tc)
  );

  assign timeout = wd_tc;
`else
  logic unused_timeout;

  assign unused_timeout = (TimeoutCycles > 0);
  assign timeout        = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    retry_inc = 1'b0;
    rec_inc   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mismatch_i && enable_i) begin
          if (retry_cnt_o < MaxRetriesC) begin
            state_d   = REQ;
            retry_inc = 1'b1;
          end else begin
            state_d = RESET;
          end
        end
      end
      REQ: begin
        if (timeout) begin
          state_d = RESET;
        end else if (debug_mode_i) begin
          state_d = RECOVER;
        end
      end
      RECOVER: begin
        // Completion beats a concurrent mismatch or timeout.
        if (recovery_done_i) begin
          state_d = IDLE;
          rec_inc = 1'b1;
        end else if (timeout) begin
          state_d = RESET;
        end
      end
      RESET: begin
        if (rst_tc) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign reset_entry = (state_d == RESET) && (state_q != RESET);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      recover_o    <= 1'b0;
      recovering_o <= 1'b0;
      reset_o      <= 1'b0;
      error_o      <= 1'b0;
      retry_cnt_o  <= '0;
      recoveries_o <= '0;
    end else begin
      state_q      <= state_d;
      recover_o    <= (state_d == REQ);
      recovering_o <= (state_d == RECOVER);
      reset_o      <= (state_d == RESET);
      if (reset_entry) begin
        error_o     <= 1'b1;
        retry_cnt_o <= '0;
      end else if (retry_inc) begin
        retry_cnt_o <= retry_cnt_o + RetryCntW'(1);
      end
      if (rec_inc && (recoveries_o != '1)) begin
        recoveries_o <= recoveries_o + RecCntW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ftm_recovery_ctrl.sv
// Directed bench for ftm_recovery_ctrl (MaxRetries=3, TimeoutCycles=16, ResetCycles=4).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Watchdog expectations follow FTM_WATCHDOG_EN.
module tb_ftm_recovery_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        mismatch;
  logic        debug_mode;
  logic        done;
  logic        recover;
  logic        recovering;
  logic        reset_out;
  logic        error;
  logic [3:0]  retry_cnt;
  logic [15:0] recoveries;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ftm_recovery_ctrl #(
    .MaxRetries    (3),
    .TimeoutCycles (16),
    .ResetCycles   (4)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .enable_i        (enable),
    .mismatch_i      (mismatch),
    .debug_mode_i    (debug_mode),
    .recovery_done_i (done),
    .recover_o       (recover),
    .recovering_o    (recovering),
    .reset_o         (reset_out),
    .error_o         (error),
    .retry_cnt_o     (retry_cnt),
    .recoveries_o    (recoveries)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_outs(input string tag, input logic rec, input logic ring,
                             input logic rst, input logic err,
                             input logic [3:0] rc, input logic [15:0] recs);
    checks += 6;
    assert (recover === rec) else begin
      failures++;
      $error("FAIL %s recover_o observed=%0b expected=%0b", tag, recover, rec);
    end
    assert (recovering === ring) else begin
      failures++;
      $error("FAIL %s recovering_o observed=%0b expected=%0b", tag, recovering, ring);
    end
    assert (reset_out === rst) else begin
      failures++;
      $error("FAIL %s reset_o observed=%0b expected=%0b", tag, reset_out, rst);
    end
    assert (error === err) else begin
      failures++;
      $error("FAIL %s error_o observed=%0b expected=%0b", tag, error, err);
    end
    assert (retry_cnt === rc) else begin
      failures++;
      $error("FAIL %s retry_cnt_o observed=%0d expected=%0d", tag, retry_cnt, rc);
    end
    assert (recoveries === recs) else begin
      failures++;
      $error("FAIL %s recoveries_o observed=%0d expected=%0d", tag, recoveries, recs);
    end
  endtask

  // One complete recovery starting from IDLE with retries still available.
  task automatic do_fault(input string tag, input logic err,
                          input logic [3:0] rc, input logic [15:0] recs);
    mismatch = 1'b1;
    step(1);
    mismatch = 1'b0;
    expect_outs({tag, "_req"}, 1'b1, 1'b0, 1'b0, err, rc, recs - 16'd1);
    debug_mode = 1'b1;
    step(1);
    debug_mode = 1'b0;
    expect_outs({tag, "_recover"}, 1'b0, 1'b1, 1'b0, err, rc, recs - 16'd1);
    done = 1'b1;
    step(1);
    done = 1'b0;
    expect_outs({tag, "_done"}, 1'b0, 1'b0, 1'b0, err, rc, recs);
  endtask

  initial begin
    rst_n      = 1'b0;
    enable     = 1'b1;
    mismatch   = 1'b0;
    debug_mode = 1'b0;
    done       = 1'b0;
    step(2);
    expect_outs("in_reset", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1);
    expect_outs("idle", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0);

    // Single fault: recover_o 3 cycles, recovering_o 10 cycles.
    mismatch = 1'b1;
    step(1);
    mismatch = 1'b0;
    expect_outs("t1_req", 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 16'd0);
    repeat (2) begin
      step(1);
      expect_outs("t1_req_hold", 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 16'd0);
    end
    debug_mode = 1'b1;
    step(1);
    expect_outs("t1_recover", 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 16'd0);
    debug_mode = 1'b0;
    repeat (9) begin
      step(1);
      expect_outs("t1_recover_hold", 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 16'd0);
    end
    done = 1'b1;
    step(1);
    done = 1'b0;
    expect_outs("t1_done", 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 16'd1);

    // Escalation on the fourth fault; mismatch held through RESET.
    do_fault("t2_f2", 1'b0, 4'd2, 16'd2);
    do_fault("t2_f3", 1'b0, 4'd3, 16'd3);
    mismatch = 1'b1;
    step(1);
    expect_outs("t2_reset", 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 16'd3);
    repeat (3) begin
      step(1);
      expect_outs("t2_reset_hold", 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 16'd3);
    end
    step(1);
    expect_outs("t2_reset_end", 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 16'd3);
    step(1);
    mismatch = 1'b0;
    expect_outs("t2_rearm", 1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 16'd3);

    // Done and mismatch together in RECOVER: one IDLE cycle, then REQ.
    debug_mode = 1'b1;
    step(1);
    debug_mode = 1'b0;
    expect_outs("t3_recover", 1'b0, 1'b1, 1'b0, 1'b1, 4'd1, 16'd3);
    done     = 1'b1;
    mismatch = 1'b1;
    step(1);
    done = 1'b0;
    expect_outs("t3_idle", 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 16'd4);
    step(1);
    mismatch = 1'b0;
    expect_outs("t3_req", 1'b1, 1'b0, 1'b0, 1'b1, 4'd2, 16'd4);
    debug_mode = 1'b1;
    step(1);
    debug_mode = 1'b0;
    expect_outs("t3_recover2", 1'b0, 1'b1, 1'b0, 1'b1, 4'd2, 16'd4);
    done = 1'b1;
    step(1);
    done = 1'b0;
    expect_outs("t3_done", 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 16'd5);

    // Disabled: a held mismatch changes nothing.
    enable   = 1'b0;
    mismatch = 1'b1;
    repeat (20) begin
      step(1);
      expect_outs("t4_disabled", 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 16'd5);
    end
    mismatch = 1'b0;
    enable   = 1'b1;

    // enable_i dropping in REQ does not abort.
    mismatch = 1'b1;
    step(1);
    mismatch = 1'b0;
    enable   = 1'b0;
    expect_outs("t5_req", 1'b1, 1'b0, 1'b0, 1'b1, 4'd3, 16'd5);
    step(1);
    expect_outs("t5_req_hold", 1'b1, 1'b0, 1'b0, 1'b1, 4'd3, 16'd5);
    debug_mode = 1'b1;
    step(1);
    debug_mode = 1'b0;
    expect_outs("t5_recover", 1'b0, 1'b1, 1'b0, 1'b1, 4'd3, 16'd5);
    done = 1'b1;
    step(1);
    done = 1'b0;
    expect_outs("t5_done", 1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 16'd6);
    enable = 1'b1;

    // Retries exhausted again: escalate, then return to IDLE.
    mismatch = 1'b1;
    step(1);
    mismatch = 1'b0;
    expect_outs("t6_reset", 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 16'd6);
    step(4);
    expect_outs("t6_idle", 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 16'd6);

    // debug_mode_i never arrives.
    mismatch = 1'b1;
    step(1);
    mismatch = 1'b0;
    expect_outs("t7_req", 1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 16'd6);
`ifdef FTM_WATCHDOG_EN
    repeat (16) begin
      step(1);
      expect_outs("t7_wd_wait", 1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 16'd6);
    end
    step(1);
    expect_outs("t7_wd_fire", 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 16'd6);
    step(4);
    expect_outs("t7_wd_idle", 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 16'd6);
    mismatch = 1'b1;
    step(1);
    mismatch = 1'b0;
    expect_outs("t7_wd_req", 1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 16'd6);
`else
    step(1000);
    expect_outs("t7_no_wd", 1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 16'd6);
`endif

    // Asynchronous reset in the middle of RECOVER.
    debug_mode = 1'b1;
    step(1);
    debug_mode = 1'b0;
    expect_outs("t8_recover", 1'b0, 1'b1, 1'b0, 1'b1, 4'd1, 16'd6);
    #2;
    rst_n = 1'b0;
    #1;
    expect_outs("t8_async_rst", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1);
    expect_outs("t8_post_idle", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0);
    mismatch = 1'b1;
    step(1);
    mismatch = 1'b0;
    expect_outs("t8_post_req", 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
